// File: rtl/gpio_bank_if.sv
// CPU-side register bus of the GPIO bank: chip select, write strobe,
// register select, write data and registered read data.
interface gpio_bank_if #(
   parameter int ADDR_W = 6
);
   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] rs;
   logic [7:0]        din;
   logic [7:0]        dout;

   modport master (output cs, we, rs, din, input dout);
   modport slave  (input cs, we, rs, din, output dout);
endinterface

// File: rtl/gpio_bank.sv
// Multi-port GPIO peripheral for the 6502 bus. Each port has OUT, DIR, PIN,
// IEN, EDGE, BOTH, FLAG and TGL registers; input edges latch into FLAG and
// enabled flags combine into one registered irq. Read data has one cycle of
// latency, like the on-chip block RAMs.
module gpio_bank #(
   parameter int NPORTS = 2,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   gpio_bank_if.slave               bus,
   input  logic [NPORTS*WIDTH-1:0]  gpio_i,
   output logic [NPORTS*WIDTH-1:0]  gpio_o,
   output logic [NPORTS*WIDTH-1:0]  gpio_oe,
   output logic                     irq
);
   localparam int NB = NPORTS * WIDTH;
   localparam int PW = ADDR_W - 3;

   localparam logic [2:0] OFF_OUT  = 3'd0;
   localparam logic [2:0] OFF_DIR  = 3'd1;
   localparam logic [2:0] OFF_PIN  = 3'd2;
   localparam logic [2:0] OFF_IEN  = 3'd3;
   localparam logic [2:0] OFF_EDGE = 3'd4;
   localparam logic [2:0] OFF_BOTH = 3'd5;
   localparam logic [2:0] OFF_FLAG = 3'd6;
   localparam logic [2:0] OFF_TGL  = 3'd7;

   logic [NB-1:0] r_out, r_dir, r_ien, r_edge, r_both, r_flag;
   logic [NB-1:0] r_s1, r_s2, r_h;
   logic [1:0]    r_prime;
   logic [7:0]    r_dout;
   logic          r_irq;

   logic [PW-1:0] w_port;
   logic [2:0]    w_off;
   logic          w_port_ok;
   logic          w_wr;
   logic          w_rd;
   logic [NB-1:0] w_clr;
   logic [NB-1:0] w_rise, w_fall, w_evt;
   logic [7:0]    w_rdata;

   assign w_port = bus.rs[ADDR_W-1:3];
   assign w_off  = bus.rs[2:0];
   assign w_wr   = bus.cs & bus.we & w_port_ok;
   assign w_rd   = bus.cs & ~bus.we;

   // Port decode, write-1-to-clear mask and read-data mux for the selected port.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_port_ok = 1'b0;
      w_clr     = '0;
      w_rdata   = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (w_port == PW'(p)) begin
            w_port_ok = 1'b1;
            if (bus.cs && bus.we && w_off == OFF_FLAG)
               w_clr[p*WIDTH +: WIDTH] = bus.din[WIDTH-1:0];
            case (w_off)
               OFF_OUT:  w_rdata[WIDTH-1:0] = r_out [p*WIDTH +: WIDTH];
               OFF_DIR:  w_rdata[WIDTH-1:0] = r_dir [p*WIDTH +: WIDTH];
               OFF_PIN:  w_rdata[WIDTH-1:0] = r_s2  [p*WIDTH +: WIDTH];
               OFF_IEN:  w_rdata[WIDTH-1:0] = r_ien [p*WIDTH +: WIDTH];
               OFF_EDGE: w_rdata[WIDTH-1:0] = r_edge[p*WIDTH +: WIDTH];
               OFF_BOTH: w_rdata[WIDTH-1:0] = r_both[p*WIDTH +: WIDTH];
               OFF_FLAG: w_rdata[WIDTH-1:0] = r_flag[p*WIDTH +: WIDTH];
               default:  w_rdata = '0;
            endcase
         end
      end
   end

   // Edge detection on the synchronised inputs, suppressed until priming completes.
   assign w_rise = r_s2 & ~r_h;
   assign w_fall = ~r_s2 & r_h;
   assign w_evt  = (r_prime == 2'd3)
                 ? ((r_both & (w_rise | w_fall)) |
                    (~r_both & ((r_edge & w_rise) | (~r_edge & w_fall))))
                 : '0;

   // CPU-writable configuration and output registers.
   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out  <= '0;
         r_dir  <= '0;
         r_ien  <= '0;
         r_edge <= '0;
         r_both <= '0;
      end else begin
         for (int p = 0; p < NPORTS; p++) begin
            if (w_wr && w_port == PW'(p)) begin
               case (w_off)
                  OFF_OUT:  r_out [p*WIDTH +: WIDTH] <= bus.din[WIDTH-1:0];
                  OFF_DIR:  r_dir [p*WIDTH +: WIDTH] <= bus.din[WIDTH-1:0];
                  OFF_IEN:  r_ien [p*WIDTH +: WIDTH] <= bus.din[WIDTH-1:0];
                  OFF_EDGE: r_edge[p*WIDTH +: WIDTH] <= bus.din[WIDTH-1:0];
                  OFF_BOTH: r_both[p*WIDTH +: WIDTH] <= bus.din[WIDTH-1:0];
                  OFF_TGL:  r_out [p*WIDTH +: WIDTH] <= r_out[p*WIDTH +: WIDTH]
                                                        ^ bus.din[WIDTH-1:0];
                  default:  ;
               endcase
            end
         end
      end
   end

   // Two-flop synchroniser plus history flop for every input bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_h  <= '0;
      end else begin
         r_s1 <= gpio_i;
         r_s2 <= r_s1;
         r_h  <= r_s2;
      end
   end

   // Priming counter: holds off events until the sync chain carries real pin levels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_prime <= 2'd0;
      else if (r_prime != 2'd3)
         r_prime <= r_prime + 2'd1;
   end

   // Interrupt flags: a new event wins over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_flag <= '0;
      else
         r_flag <= w_evt | (r_flag & ~w_clr);
   end

   // Registered read data, loaded on every read cycle and held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_dout <= 8'h00;
      else if (w_rd)
         r_dout <= w_rdata;
   end

   // Registered interrupt request from all enabled flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_irq <= 1'b0;
      else
         r_irq <= |(r_flag & r_ien);
   end

   assign bus.dout = r_dout;
   assign gpio_o   = r_out;
   assign gpio_oe  = r_dir;
   assign irq      = r_irq;
endmodule

// File: tb/tb_gpio_bank.sv
// Directed testbench for gpio_bank (NPORTS=2, WIDTH=8, ADDR_W=6).
module tb_gpio_bank;
   logic        clk;
   logic        reset;
   logic [15:0] gpio_i;
   logic [15:0] gpio_o;
   logic [15:0] gpio_oe;
   logic        irq;
   int          n_checks;
   int          n_errors;

   gpio_bank_if #(.ADDR_W(6)) bus ();

   gpio_bank #(.NPORTS(2), .WIDTH(8), .ADDR_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .gpio_oe (gpio_oe),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single write cycle: bus driven from one falling edge to the next.
   task automatic bus_write(input int port, input int off, input logic [7:0] data);
      logic [2:0] pp, oo;
      pp = port[2:0];
      oo = off[2:0];
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b1; bus.rs = {pp, oo}; bus.din = data;
      @(negedge clk);
      bus.cs = 1'b0; bus.we = 1'b0;
   endtask

   // Single read cycle: data is sampled on the falling edge after the loading edge.
   task automatic bus_read(input int port, input int off, output logic [7:0] data);
      logic [2:0] pp, oo;
      pp = port[2:0];
      oo = off[2:0];
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b0; bus.rs = {pp, oo};
      @(negedge clk);
      bus.cs = 1'b0;
      data = bus.dout;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; gpio_i = 16'h0000;
      bus.cs = 1'b0; bus.we = 1'b0; bus.rs = '0; bus.din = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (gpio_o !== 16'h0000) begin n_errors++; $display("FAIL reset_gpio_o got %h exp 0000", gpio_o); end
      n_checks++;
      if (gpio_oe !== 16'h0000) begin n_errors++; $display("FAIL reset_gpio_oe got %h exp 0000", gpio_oe); end
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      n_checks++;
      if (bus.dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
      for (int p = 0; p < 2; p++) begin
         for (int o = 0; o < 8; o++) begin
            bus_read(p, o, d);
            n_checks++;
            if (d !== 8'h00) begin
               n_errors++; $display("FAIL reset_reg p%0d o%0d got %h exp 00", p, o, d);
            end
         end
      end
   endtask

   task automatic test_out_dir_tgl();
      logic [7:0] d;
      bus_write(1, 0, 8'hA5);
      bus_write(1, 1, 8'hF0);
      bus_write(1, 7, 8'h0F);
      bus_read(1, 0, d);
      n_checks++;
      if (d !== 8'hAA) begin n_errors++; $display("FAIL tgl_out1 got %h exp AA", d); end
      n_checks++;
      if (gpio_o !== 16'hAA00) begin n_errors++; $display("FAIL tgl_gpio_o got %h exp AA00", gpio_o); end
      n_checks++;
      if (gpio_oe !== 16'hF000) begin n_errors++; $display("FAIL dir_gpio_oe got %h exp F000", gpio_oe); end
      bus_read(1, 1, d);
      n_checks++;
      if (d !== 8'hF0) begin n_errors++; $display("FAIL dir1_read got %h exp F0", d); end
      bus_read(1, 7, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL tgl_read got %h exp 00", d); end
      bus_read(0, 0, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL out0_untouched got %h exp 00", d); end
   endtask

   task automatic test_edge_irq();
      logic [7:0] d;
      bus_write(0, 4, 8'h01);
      bus_write(0, 3, 8'h01);
      @(negedge clk);
      gpio_i[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL rise_irq_early got %b exp 0", irq); end
      @(posedge clk);
      #1;
      n_checks++;
      if (irq !== 1'b1) begin n_errors++; $display("FAIL rise_irq got %b exp 1", irq); end
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h01) begin n_errors++; $display("FAIL rise_flag got %h exp 01", d); end
      bus_write(0, 6, 8'h01);
      n_checks++;
      if (irq !== 1'b1) begin n_errors++; $display("FAIL w1c_irq_hold got %b exp 1", irq); end
      @(posedge clk);
      #1;
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL w1c_irq_clear got %b exp 0", irq); end
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL w1c_flag got %h exp 00", d); end
   endtask

   task automatic test_both_mask();
      logic [7:0] d;
      bus_write(0, 3, 8'h00);
      bus_write(0, 5, 8'h80);
      gpio_i[7] = 1'b1;
      repeat (4) @(negedge clk);
      gpio_i[7] = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h80) begin n_errors++; $display("FAIL both_flag got %h exp 80", d); end
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL both_masked_irq got %b exp 0", irq); end
      bus_write(0, 3, 8'h80);
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL ien_irq_early got %b exp 0", irq); end
      @(posedge clk);
      #1;
      n_checks++;
      if (irq !== 1'b1) begin n_errors++; $display("FAIL ien_irq got %b exp 1", irq); end
      bus_write(0, 6, 8'h80);
      bus_write(0, 3, 8'h00);
   endtask

   task automatic test_prime_w1c();
      logic [7:0] d;
      @(negedge clk);
      reset  = 1'b1;
      gpio_i = 16'hFFFF;
      #1;
      n_checks++;
      if (gpio_o !== 16'h0000 || gpio_oe !== 16'h0000 || irq !== 1'b0) begin
         n_errors++; $display("FAIL reset_async got o=%h oe=%h irq=%b exp 0", gpio_o, gpio_oe, irq);
      end
      repeat (2) @(negedge clk);
      // Configure BOTH on the first edge after release so unprimed events would show.
      bus.cs = 1'b1; bus.we = 1'b1; bus.rs = {3'd0, 3'd5}; bus.din = 8'hFF;
      reset = 1'b0;
      @(negedge clk);
      bus.cs = 1'b0; bus.we = 1'b0;
      repeat (6) @(negedge clk);
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL prime_flag0 got %h exp 00", d); end
      bus_read(1, 6, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL prime_flag1 got %h exp 00", d); end
      bus_read(0, 2, d);
      n_checks++;
      if (d !== 8'hFF) begin n_errors++; $display("FAIL pin0 got %h exp FF", d); end
      bus_write(0, 5, 8'h00);
      // Falling edge on bit 3 with a W1C landing on the same edge the flag sets.
      @(negedge clk);
      gpio_i[3] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b1; bus.rs = {3'd0, 3'd6}; bus.din = 8'h08;
      @(negedge clk);
      bus.cs = 1'b0; bus.we = 1'b0;
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h08) begin n_errors++; $display("FAIL set_wins_clear got %h exp 08", d); end
      bus_write(0, 6, 8'h08);
      bus_read(0, 6, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL fall_w1c got %h exp 00", d); end
   endtask

   task automatic test_bad_port();
      logic [7:0] d;
      bus_write(3, 0, 8'h55);
      bus_write(3, 1, 8'h55);
      bus_write(2, 0, 8'h55);
      n_checks++;
      if (gpio_o !== 16'h0000) begin n_errors++; $display("FAIL bad_port_out got %h exp 0000", gpio_o); end
      n_checks++;
      if (gpio_oe !== 16'h0000) begin n_errors++; $display("FAIL bad_port_dir got %h exp 0000", gpio_oe); end
      bus_read(3, 0, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL bad_port_read got %h exp 00", d); end
      bus_read(3, 2, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL bad_port_pin got %h exp 00", d); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      bus_write(0, 0, 8'h3C);
      bus_write(0, 1, 8'hC3);
      bus_read(0, 0, d);
      n_checks++;
      if (d !== 8'h3C) begin n_errors++; $display("FAIL pre_reset_out got %h exp 3C", d); end
      @(negedge clk);
      n_checks++;
      if (bus.dout !== 8'h3C) begin n_errors++; $display("FAIL dout_hold got %h exp 3C", bus.dout); end
      bus.cs = 1'b1; bus.we = 1'b1; bus.rs = {3'd0, 3'd0}; bus.din = 8'hFF;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (gpio_o !== 16'h0000 || gpio_oe !== 16'h0000 || irq !== 1'b0 || bus.dout !== 8'h00) begin
         n_errors++;
         $display("FAIL mid_reset got o=%h oe=%h irq=%b dout=%h exp 0", gpio_o, gpio_oe, irq, bus.dout);
      end
      @(negedge clk);
      bus.cs = 1'b0; bus.we = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus_read(0, 0, d);
      n_checks++;
      if (d !== 8'h00) begin n_errors++; $display("FAIL post_reset_out got %h exp 00", d); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_out_dir_tgl();
      test_edge_irq();
      test_both_mask();
      test_prime_w1c();
      test_bad_port();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
